btn_evt_queue: RTL and testbench
================================

// Module: btn_evt_queue
// PURPOSE
//   Collects one-cycle press pulses from NUM_BTN debounced buttons and queues them
//   as ordered key events for the note/game logic.
//   Presses on the same cycle are serialised lowest index first. Events are held in
//   a DEPTH-entry FIFO and handed to the consumer with a valid/ready handshake.
//   Sits between the per-button debouncers and the note-matching state machine.
// PARAMETERS
//   NUM_BTN  4  number of button pulse inputs (2..16)
//   DEPTH    8  FIFO entries (power of 2, >=2)
//   IDX_W    2  event code width, must equal clog2(NUM_BTN)
// PORTS
//   clk        in   1        clock
//   rst        in   1        reset, synchronous, active-high
//   ena        in   1        capture enable; pulses are ignored while low
//   flush      in   1        sync clear of pending bits and FIFO (not overflow)
//   btn_pulse  in   NUM_BTN  one-cycle press pulses, one bit per button
//   evt_valid  out  1        head event available
//   evt_code   out  IDX_W    button index of head event
//   evt_ready  in   1        consumer accepts head when evt_valid&&evt_ready
//   evt_count  out  clog2(DEPTH)+1  entries currently in FIFO
//   overflow   out  1        sticky: a press was lost; cleared only by rst
// BEHAVIOUR
//   - Reset (rst high at an edge):
//     - pending=0, FIFO empty, evt_valid=0, evt_code=0, evt_count=0, overflow=0.
//     - rst overrides flush and all other inputs, including mid-operation.
//   - Capture, each edge with ena=1:
//     - pending[i] <= 1 for every btn_pulse[i]=1.
//     - Pulse on a bit already pending and not being drained this cycle:
//       press dropped, overflow <= 1.
//     - ena=0: btn_pulse ignored; pending contents kept and still drained.
//   - Drain, each edge:
//     - lowest-index set pending bit i is pushed as code i and its bit cleared.
//     - Push allowed when evt_count<DEPTH, or when evt_count==DEPTH and a pop
//       happens the same edge.
//     - Otherwise pending holds (back-pressure); no loss until a repeat press.
//     - At most one push and one pop per edge.
//     - A new pulse on the bit being drained re-sets it (counts as new press).
//   - Latency: pulse sampled at edge E0, empty FIFO -> evt_valid=1 with the code
//     after edge E1. Same-cycle pulses on k buttons emerge on k consecutive cycles.
//   - FIFO:
//     - Show-ahead; evt_code is valid whenever evt_valid=1 and is held stable until popped.
//     - evt_valid = (evt_count!=0).
//     - Pop when evt_valid&&evt_ready.
//     - Read/write pointers wrap modulo DEPTH.
//     - evt_count: +1 on push only, -1 on pop only, unchanged on both.
//     - Pop on empty is a no-op.
//   - flush (rst=0): pending, FIFO and evt_count cleared at the edge. Pulses on the
//     flush cycle are discarded. overflow is unaffected.
//   - evt_code is registered; no combinational path from btn_pulse to any output.
// TESTING
//   - Reset:
//     - rst 2 cycles with btn_pulse=4'hF -> evt_valid=0, evt_count=0, overflow=0.
//   - Single press, evt_ready=1:
//     - pulse btn 2 at E0 -> evt_valid=1, code=2 after E1 for exactly 1 cycle.
//   - Simultaneous presses, evt_ready=0:
//     - btn_pulse=4'b1011 -> codes 0,1,3 after E1,E2,E3; evt_count=3.
//   - Full FIFO, evt_ready=0:
//     - 8 presses -> evt_count=8; press btn1 -> stays pending.
//     - press btn1 again -> overflow=1.
//     - then evt_ready=1 -> 9 events total drain in order.
//   - Push+pop at full:
//     - count=8, pop and pending push same edge -> count stays 8, order preserved.
//   - ena=0, flush and rst mid-operation:
//     - pulses with ena=0 -> no events.
//     - flush with count=5 -> count=0 next cycle, overflow unchanged.
//     - rst while pending -> all outputs 0.

Source files
------------

// File: rtl/btn_evt_queue_if.sv
// Key-event handshake between the button event queue and its consumer.
// The queue drives valid/code; the note-matching logic drives ready.
interface btn_evt_queue_if #(
  parameter int IDX_W = 2
);
  logic             evt_valid;
  logic [IDX_W-1:0] evt_code;
  logic             evt_ready;

  modport master (
    output evt_valid,
    output evt_code,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    output evt_ready
  );
endinterface

// File: rtl/btn_evt_queue.sv
// Turns debounced one-cycle button press pulses into an ordered stream of key events.
// Same-cycle presses are serialised lowest index first through a show-ahead FIFO.
module btn_evt_queue #(
  parameter  int NUM_BTN = 4,
  parameter  int DEPTH   = 8,
  parameter  int IDX_W   = 2,
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 flush,
  input  logic [NUM_BTN-1:0]   btn_pulse,
  btn_evt_queue_if.master      evt,
  output logic [CNT_W-1:0]     evt_count,
  output logic                 overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [NUM_BTN-1:0] pending;
  logic [IDX_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  logic [IDX_W-1:0]   drain_idx;
  logic               drain_hit;
  logic               pop;
  logic               push;
  logic [NUM_BTN-1:0] drain_mask;
  logic [NUM_BTN-1:0] capture;
  logic [NUM_BTN-1:0] repeat_hit;

  // Scan from the top down so the last assignment wins: lowest pending index.
  always_comb begin
    drain_idx = '0;
    drain_hit = 1'b0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (pending[i]) begin
        drain_idx = IDX_W'(i);
        drain_hit = 1'b1;
      end
    end
  end

  assign pop        = (evt_count != '0) && evt.evt_ready;
  assign push       = drain_hit && ((evt_count < CNT_W'(DEPTH)) || pop);
  assign drain_mask = push ? (NUM_BTN'(1) << drain_idx) : '0;
  assign capture    = ena ? btn_pulse : '0;
  // A press on a bit that is still waiting (and not leaving this edge) is lost.
  assign repeat_hit = capture & pending & ~drain_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      evt_count <= '0;
      overflow  <= 1'b0;
    end else if (flush) begin
      pending   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      evt_count <= '0;
    end else begin
      pending <= (pending & ~drain_mask) | capture;
      if (|repeat_hit) begin
        overflow <= 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   evt_count <= evt_count + CNT_W'(1);
        2'b01:   evt_count <= evt_count - CNT_W'(1);
        default: evt_count <= evt_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      mem[wr_ptr] <= drain_idx;
    end
  end

  // Code is forced to zero while empty so stale storage never shows.
  assign evt.evt_valid = (evt_count != '0);
  assign evt.evt_code  = evt.evt_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_btn_evt_queue.sv
// Directed and randomized checks of btn_evt_queue against a queue-based reference model.
module tb_btn_evt_queue;
  localparam int NUM_BTN = 4;
  localparam int DEPTH   = 8;
  localparam int IDX_W   = 2;
  localparam int CNT_W   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               ena;
  logic               flush;
  logic [NUM_BTN-1:0] btn_pulse;
  logic [CNT_W-1:0]   evt_count;
  logic               overflow;

  btn_evt_queue_if #(.IDX_W(IDX_W)) evt_if ();

  btn_evt_queue #(
    .NUM_BTN(NUM_BTN),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .flush    (flush),
    .btn_pulse(btn_pulse),
    .evt      (evt_if),
    .evt_count(evt_count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int       m_q[$];
  bit [3:0] m_pend;
  bit       m_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [3:0] p, input logic e, input logic r,
                            input logic f, input logic rs);
    int lo;
    bit do_pop;
    bit do_push;
    if (rs) begin
      m_q.delete();
      m_pend = '0;
      m_ovf  = 1'b0;
    end else if (f) begin
      m_q.delete();
      m_pend = '0;
    end else begin
      do_pop = (m_q.size() > 0) && r;
      lo = -1;
      for (int i = 0; i < NUM_BTN; i++) if (m_pend[i] && lo < 0) lo = i;
      do_push = (lo >= 0) && ((m_q.size() < DEPTH) || do_pop);
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        m_q.push_back(lo);
        m_pend[lo] = 1'b0;
      end
      if (e) begin
        for (int i = 0; i < NUM_BTN; i++) begin
          if (p[i]) begin
            if (m_pend[i]) m_ovf = 1'b1;
            else m_pend[i] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic check_model();
    check("valid", 32'(evt_if.evt_valid), 32'(m_q.size() != 0));
    check("count", 32'(evt_count), 32'(m_q.size()));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (m_q.size() != 0) check("code", 32'(evt_if.evt_code), 32'(m_q[0]));
  endtask

  task automatic cycle(input logic [3:0] p, input logic e, input logic r,
                       input logic f, input logic rs);
    btn_pulse        = p;
    ena              = e;
    evt_if.evt_ready = r;
    flush            = f;
    rst              = rs;
    @(posedge clk);
    model_edge(p, e, r, f, rs);
    @(negedge clk);
    check_model();
  endtask

  initial begin
    btn_pulse = '0; ena = 1'b1; flush = 1'b0; rst = 1'b1; evt_if.evt_ready = 1'b0;
    m_pend = '0; m_ovf = 1'b0;

    // Reset held two cycles with all buttons pressed
    cycle(4'hF, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(4'hF, 1'b1, 1'b0, 1'b0, 1'b1);
    check("rst_valid", 32'(evt_if.evt_valid), 32'd0);
    check("rst_code", 32'(evt_if.evt_code), 32'd0);
    check("rst_count", 32'(evt_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);

    // Single press on button 2 with consumer ready
    cycle(4'b0100, 1'b1, 1'b1, 1'b0, 1'b0);
    check("single_e0_valid", 32'(evt_if.evt_valid), 32'd0);
    cycle(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
    check("single_e1_valid", 32'(evt_if.evt_valid), 32'd1);
    check("single_e1_code", 32'(evt_if.evt_code), 32'd2);
    cycle(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
    check("single_e2_valid", 32'(evt_if.evt_valid), 32'd0);

    // Simultaneous presses serialise lowest first
    cycle(4'b1011, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    check("simul_cnt1", 32'(evt_count), 32'd1);
    cycle(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    check("simul_cnt3", 32'(evt_count), 32'd3);
    check("simul_head", 32'(evt_if.evt_code), 32'd0);
    cycle(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
    check("simul_head2", 32'(evt_if.evt_code), 32'd1);
    cycle(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
    check("simul_head3", 32'(evt_if.evt_code), 32'd3);
    cycle(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
    check("simul_empty", 32'(evt_count), 32'd0);

    // Fill the FIFO, then back-pressure and overflow
    for (int k = 0; k < DEPTH; k++) cycle(4'(1 << (k % 4)), 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    check("full_cnt", 32'(evt_count), 32'd8);
    cycle(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    check("full_hold_cnt", 32'(evt_count), 32'd8);
    check("full_hold_ovf", 32'(overflow), 32'd0);
    cycle(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
    check("full_ovf", 32'(overflow), 32'd1);
    cycle(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
    check("pushpop_cnt", 32'(evt_count), 32'd8);
    check("pushpop_head", 32'(evt_if.evt_code), 32'd1);
    for (int k = 0; k < 9; k++) cycle(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
    check("drain_empty", 32'(evt_count), 32'd0);

    // Pulses ignored while capture is disabled
    for (int k = 0; k < 3; k++) cycle(4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ena0_cnt", 32'(evt_count), 32'd0);

    // Flush with five entries queued
    for (int k = 0; k < 5; k++) cycle(4'(1 << (k % 4)), 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    check("preflush_cnt", 32'(evt_count), 32'd5);
    cycle(4'b0110, 1'b1, 1'b0, 1'b1, 1'b0);
    check("flush_cnt", 32'(evt_count), 32'd0);
    check("flush_ovf", 32'(overflow), 32'd1);
    cycle(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    check("postflush_cnt", 32'(evt_count), 32'd0);

    // Reset while presses are pending
    cycle(4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("midrst_valid", 32'(evt_if.evt_valid), 32'd0);
    check("midrst_cnt", 32'(evt_count), 32'd0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    cycle(4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("midrst_pend_gone", 32'(evt_count), 32'd0);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      logic [3:0] p;
      p = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      cycle(p, ($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 60) == 0), ($urandom_range(0, 200) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
